crtc2: RTL and testbench
========================

# crtc2

Parametrised second-generation CRT controller for the CGIA video path. It generates horizontal and vertical dot/line counters, programmable-polarity sync pulses with explicit start and end, a horizontal display enable and a vertical fetch enable. It also produces a frame-start strobe and a raster-compare interrupt. It sits between the dot-clock domain root and the fetch/shift pipeline, replacing the fixed 10-bit CRTC.

## Interface
- `CW`, 10: counter and timing-register width; legal range 8–14.
- `dotclk_i` in 1: dot clock; all state on rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `dotce_i` in 1: dot enable; counters and outputs advance only when 1. Tie high for one dot per clock.
- `htotal_i`, `vtotal_i` in CW: last dot / last line index; period is total+1.
- `hsstart_i`, `hsend_i`, `vsstart_i`, `vsend_i` in CW: sync window start and end.
- `hspol_i`, `vspol_i` in 1: 1 = sync active-high, 0 = active-low.
- `hvstart_i`, `hvend_i`, `vvstart_i`, `vvend_i` in CW: display/fetch window bounds.
- `rcmp_i` in CW: raster-compare line.
- `irqack_i` in 1: clears pending raster IRQ.
- `x_o`, `y_o` out CW: current dot and line.
- `hsync_o`, `vsync_o` out 1: polarity-applied sync.
- `hden_o`, `vfen_o` out 1: horizontal display enable, vertical fetch enable.
- `frame_o` out 1: one-dot strobe on the first dot of each frame.
- `irq_o` out 1: raster interrupt, level, sticky until acked.

## Operation
- All state updates are qualified by `dotce_i`, except `irqack_i` clear, which acts on any clock.
- X: increments each dot; at `x_o == htotal_i` it wraps to 0 and Y advances. Y wraps to 0 after `vtotal_i`.
- End-of-line (EOL) = `x_o == htotal_i`; end-of-frame (EOF) = EOL and `y_o == vtotal_i`.
- Horizontal sync flag:
  - sets on the dot X becomes `hsstart_i`;
  - clears on the dot X becomes `hsend_i`;
  - clears when X wraps to 0 if `hsend_i > htotal_i`.
  - `hsstart_i == hsend_i` means no pulse.
  - `hsync_o = flag XNOR hspol_i`, i.e. active level equals `hspol_i`.
- Vertical sync: same rule on Y, evaluated at EOL, so it changes on X=0 of the new line.
- `hden_o`: high for dots with X in `hvstart_i+1 .. hvend_i` (one-dot pipeline delay to match the fetch stage).
- `vfen_o`:
  - set at EOL when `y_o == vvstart_i`;
  - cleared at EOL when `y_o == vvend_i`;
  - the change is visible from X=0 of the next line.
  - If both match on the same line, clear wins.
- `frame_o`: high for exactly the dot X=0, Y=0 after an EOF wrap. It is not asserted after reset.
- Raster IRQ:
  - at EOL with `y_o == rcmp_i`, the pending flag sets; visible on the next line's X=0;
  - `irqack_i` clears it on the next clock;
  - set and ack in the same cycle: set wins.
- Timing inputs are sampled live. Changing totals mid-line to a value below the current count lets X run on to 2^CW−1 and wrap naturally; there is no lockup.
- Arithmetic is unsigned CW-bit with natural wrap. `hvstart_i+1` is computed in CW bits.

## Timing
- Reset values:
  - `x_o`, `y_o`, `hden_o`, `vfen_o`, `frame_o`, `irq_o` = 0;
  - sync flags = 0, so `hsync_o` / `vsync_o` reset to the inactive level (`~hspol_i` / `~vspol_i`).
- First enabled dot after reset release: X=1.
- Reset asserted mid-frame returns everything to reset values immediately; there is no partial-state carry-over.
- All outputs are registered except the sync polarity XOR, which is combinational from the flag and the pol input.

## Configuration
- `CRTC2_RASTER_IRQ_EN`: when defined, `rcmp_i`, `irqack_i`, `irq_o` and the pending flag are built as above.
- When undefined, the ports remain, inputs are ignored, and `irq_o` is tied 0.

## Structure
- `crtc2_pkg`:
  - `CW` default constant;
  - `crtc2_timing_t` struct (total, sstart, send, vstart, vend per axis);
  - polarity localparams `SYNC_POS` / `SYNC_NEG`.
- Sub-module `crtc2_axis`:
  - one counter with wrap and advance input;
  - sync-window flag;
  - display-window flag.
- `crtc2_axis` is instantiated twice:
  - horizontal, advancing on `dotce_i`;
  - vertical, advancing on `dotce_i` and EOL, with the window evaluated at EOL.
- The top level adds the polarity XOR, `frame_o` and the IRQ.

## Test plan
- Reset with `htotal_i`=799, `vtotal_i`=524: X=Y=0, all flags 0. Release: X=1 after one dot, 2 after two. With `dotce_i`=0 for 3 clocks, X holds.
- `htotal_i`=5, `hsstart_i`=3, `hsend_i`=5, `hspol_i`=1: `hsync_o` is 1 at X=3,4 and 0 at X=5,0. With `hspol_i`=0 the levels invert; `hsync_o` is 1 during reset.
- `htotal_i`=5, `vtotal_i`=3, `vsstart_i`=2, `vsend_i`=3: `vsync_o` is active for Y=2 only; Y returns to 0 after line 3 and `frame_o` pulses for one dot at X=0, Y=0.
- `hvstart_i`=1, `hvend_i`=4: `hden_o` is 1 for X=2..4 and 0 at X=5 and X=0–1. `vvstart_i`=0, `vvend_i`=2: `vfen_o` rises at X=0, Y=1 and falls at X=0, Y=3.
- IRQ enabled, `rcmp_i`=1: `irq_o` rises at X=0, Y=2 and holds across lines. `irqack_i` pulse clears it next clock. An ack coinciding with EOL on Y=1 leaves it set.
- Reset asserted at X=3, Y=2 with `vfen_o`=1 and `irq_o`=1: all outputs clear asynchronously; after release the count restarts at X=1, Y=0.

Source files
------------

// File: rtl/crtc2_pkg.sv
// ============================================================================
// Module      : crtc2_pkg
// Description : Shared constants and timing bundle for the crtc2 CRT controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package crtc2_pkg;

    localparam int CW_DEFAULT = 10;
    localparam int CW_MAX     = 14;

    localparam logic SYNC_POS = 1'b1;
    localparam logic SYNC_NEG = 1'b0;

    // Fields are sized for the widest legal counter; narrower builds zero-extend.
    typedef struct packed {
        logic [CW_MAX-1:0] total;
        logic [CW_MAX-1:0] sstart;
        logic [CW_MAX-1:0] send;
        logic [CW_MAX-1:0] vstart;
        logic [CW_MAX-1:0] vend;
    } crtc2_timing_t;

endpackage

`default_nettype wire

// File: rtl/crtc2_axis.sv
// ============================================================================
// Module      : crtc2_axis
// Description : One raster axis: wrapping counter, sync-window flag and
//               display-window flag, all advancing on i_adv.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crtc2_axis
    import crtc2_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_adv,
    input  crtc2_timing_t i_tim,
    output logic [CW-1:0] o_cnt,
    output logic          o_last,
    output logic          o_sync,
    output logic          o_win
);

    localparam logic [CW-1:0] c_one = CW'(1);

    logic [CW-1:0]     r_cnt;
    logic              r_sync;
    logic              r_win;
    logic [CW-1:0]     w_inc;
    logic [CW_MAX-1:0] w_cnt_ext;
    logic [CW_MAX-1:0] w_next_ext;
    logic              w_last;

    // Compare at full width so every timing bit participates.
    assign w_inc      = r_cnt + c_one;
    assign w_cnt_ext  = CW_MAX'(r_cnt);
    assign w_last     = (w_cnt_ext == i_tim.total);
    assign w_next_ext = w_last ? '0 : CW_MAX'(w_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_sync <= 1'b0;
            r_win  <= 1'b0;
        end else if (i_adv) begin
            r_cnt <= w_next_ext[CW-1:0];
            // Clear has priority, so an empty window (start == end) never pulses.
            if (w_next_ext == i_tim.send)
                r_sync <= 1'b0;
            else if (w_last && (i_tim.send > i_tim.total))
                r_sync <= 1'b0;
            else if (w_next_ext == i_tim.sstart)
                r_sync <= 1'b1;
            if (w_cnt_ext == i_tim.vend)
                r_win <= 1'b0;
            else if (w_cnt_ext == i_tim.vstart)
                r_win <= 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;
    assign o_sync = r_sync;
    assign o_win  = r_win;

endmodule

`default_nettype wire

// File: rtl/crtc2.sv
// ============================================================================
// Module      : crtc2
// Description : Parametrised CRT controller: dot/line counters, programmable
//               sync, display/fetch enables, frame strobe and raster IRQ.
//               Raster IRQ built only when CRTC2_RASTER_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crtc2
    import crtc2_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          dotclk_i,
    input  logic          reset_i,
    input  logic          dotce_i,
    input  logic [CW-1:0] htotal_i,
    input  logic [CW-1:0] vtotal_i,
    input  logic [CW-1:0] hsstart_i,
    input  logic [CW-1:0] hsend_i,
    input  logic [CW-1:0] vsstart_i,
    input  logic [CW-1:0] vsend_i,
    input  logic          hspol_i,
    input  logic          vspol_i,
    input  logic [CW-1:0] hvstart_i,
    input  logic [CW-1:0] hvend_i,
    input  logic [CW-1:0] vvstart_i,
    input  logic [CW-1:0] vvend_i,
    input  logic [CW-1:0] rcmp_i,
    input  logic          irqack_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          hden_o,
    output logic          vfen_o,
    output logic          frame_o,
    output logic          irq_o
);

    crtc2_timing_t w_htim;
    crtc2_timing_t w_vtim;
    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic          w_heol;
    logic          w_vlast;
    logic          w_eof;
    logic          w_hflag;
    logic          w_vflag;
    logic          w_vadv;
    logic          r_frame;

    assign w_htim = '{total:  CW_MAX'(htotal_i),
                      sstart: CW_MAX'(hsstart_i),
                      send:   CW_MAX'(hsend_i),
                      vstart: CW_MAX'(hvstart_i),
                      vend:   CW_MAX'(hvend_i)};
    assign w_vtim = '{total:  CW_MAX'(vtotal_i),
                      sstart: CW_MAX'(vsstart_i),
                      send:   CW_MAX'(vsend_i),
                      vstart: CW_MAX'(vvstart_i),
                      vend:   CW_MAX'(vvend_i)};

    crtc2_axis #(.CW(CW)) u_haxis (
        .clk    (dotclk_i),
        .rst_n  (reset_i),
        .i_adv  (dotce_i),
        .i_tim  (w_htim),
        .o_cnt  (w_x),
        .o_last (w_heol),
        .o_sync (w_hflag),
        .o_win  (hden_o)
    );

    // The vertical axis steps once per line, so its windows resolve at EOL.
    assign w_vadv = dotce_i & w_heol;

    crtc2_axis #(.CW(CW)) u_vaxis (
        .clk    (dotclk_i),
        .rst_n  (reset_i),
        .i_adv  (w_vadv),
        .i_tim  (w_vtim),
        .o_cnt  (w_y),
        .o_last (w_vlast),
        .o_sync (w_vflag),
        .o_win  (vfen_o)
    );

    assign w_eof = w_heol & w_vlast;

    always_ff @(posedge dotclk_i or negedge reset_i) begin
        if (!reset_i)
            r_frame <= 1'b0;
        else if (dotce_i)
            r_frame <= w_eof;
    end

`ifdef CRTC2_RASTER_IRQ_EN
    logic r_irq;

    // Set wins over a coincident ack; ack is not gated by the dot enable.
    always_ff @(posedge dotclk_i or negedge reset_i) begin
        if (!reset_i)
            r_irq <= 1'b0;
        else if (w_vadv && (w_y == rcmp_i))
            r_irq <= 1'b1;
        else if (irqack_i)
            r_irq <= 1'b0;
    end

    assign irq_o = r_irq;
`else
    logic w_unused_irq;

    assign w_unused_irq = ^{rcmp_i, irqack_i};
    assign irq_o        = 1'b0;
`endif

    assign x_o     = w_x;
    assign y_o     = w_y;
    assign hsync_o = (hspol_i == SYNC_POS) ? w_hflag : ~w_hflag;
    assign vsync_o = (vspol_i == SYNC_NEG) ? ~w_vflag : w_vflag;
    assign frame_o = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_crtc2.sv
// ============================================================================
// Module      : tb_crtc2
// Description : Self-checking bench for crtc2; reference model derives every
//               output from the enabled-dot count since reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crtc2;

    localparam int CW = 10;

    logic          r_clk = 1'b0;
    logic          r_rst_n = 1'b0;
    logic          r_dotce = 1'b0;
    logic          r_irqack = 1'b0;
    logic          r_hspol = 1'b1;
    logic          r_vspol = 1'b1;
    logic [CW-1:0] r_htotal, r_vtotal, r_hss, r_hse, r_vss, r_vse;
    logic [CW-1:0] r_hvs, r_hve, r_vvs, r_vve, r_rcmp;
    logic [CW-1:0] w_x, w_y;
    logic          w_hsync, w_vsync, w_hden, w_vfen, w_frame, w_irq;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_n      = 0;
    logic m_irq    = 1'b0;

    always #5 r_clk = ~r_clk;

    crtc2 #(.CW(CW)) dut (
        .dotclk_i  (r_clk),
        .reset_i   (r_rst_n),
        .dotce_i   (r_dotce),
        .htotal_i  (r_htotal),
        .vtotal_i  (r_vtotal),
        .hsstart_i (r_hss),
        .hsend_i   (r_hse),
        .vsstart_i (r_vss),
        .vsend_i   (r_vse),
        .hspol_i   (r_hspol),
        .vspol_i   (r_vspol),
        .hvstart_i (r_hvs),
        .hvend_i   (r_hve),
        .vvstart_i (r_vvs),
        .vvend_i   (r_vve),
        .rcmp_i    (r_rcmp),
        .irqack_i  (r_irqack),
        .x_o       (w_x),
        .y_o       (w_y),
        .hsync_o   (w_hsync),
        .vsync_o   (w_vsync),
        .hden_o    (w_hden),
        .vfen_o    (w_vfen),
        .frame_o   (w_frame),
        .irq_o     (w_irq)
    );

    // Reference model: position is the enabled-dot count folded by the raster size.
    function automatic int mx();
        return m_n % (int'(r_htotal) + 1);
    endfunction

    function automatic int my();
        return (m_n / (int'(r_htotal) + 1)) % (int'(r_vtotal) + 1);
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic e_hsync();
        logic f;
        f = (mx() >= int'(r_hss)) && (mx() < imin(int'(r_hse), int'(r_htotal) + 1));
        return f ~^ r_hspol;
    endfunction

    function automatic logic e_vsync();
        logic f;
        f = (my() >= int'(r_vss)) && (my() < imin(int'(r_vse), int'(r_vtotal) + 1));
        return f ~^ r_vspol;
    endfunction

    function automatic logic e_hden();
        return (mx() >= int'(r_hvs) + 1) && (mx() <= int'(r_hve));
    endfunction

    function automatic logic e_vfen();
        return (my() >= int'(r_vvs) + 1) && (my() <= int'(r_vve));
    endfunction

    function automatic logic e_frame();
        return (m_n > 0) && (mx() == 0) && (my() == 0);
    endfunction

    task automatic step(input logic ce, input logic ack);
        int px, py;
        r_dotce  = ce;
        r_irqack = ack;
        px = mx();
        py = my();
        @(posedge r_clk);
`ifdef CRTC2_RASTER_IRQ_EN
        if (ce && px == int'(r_htotal) && py == int'(r_rcmp))
            m_irq = 1'b1;
        else if (ack)
            m_irq = 1'b0;
`endif
        if (ce)
            m_n++;
        #1;
        r_irqack = 1'b0;
    endtask

    task automatic do_reset();
        r_rst_n  = 1'b0;
        r_dotce  = 1'b1;
        r_irqack = 1'b0;
        m_n      = 0;
        m_irq    = 1'b0;
        repeat (2) @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;
    endtask

    task automatic set_small();
        r_htotal = 10'd5;  r_vtotal = 10'd3;
        r_hss = 10'd3;     r_hse = 10'd5;
        r_vss = 10'd2;     r_vse = 10'd3;
        r_hvs = 10'd1;     r_hve = 10'd4;
        r_vvs = 10'd0;     r_vve = 10'd2;
        r_rcmp = 10'd1;
        r_hspol = 1'b1;    r_vspol = 1'b1;
    endtask

    task automatic test_reset();
        set_small();
        r_htotal = 10'd799;
        r_vtotal = 10'd524;
        @(negedge r_clk);
        r_rst_n = 1'b0;
        r_dotce = 1'b1;
        #1;
        n_checks++;
        if ({w_x, w_y} !== {CW'(0), CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_xy: x=%0d y=%0d expected 0 0", w_x, w_y);
        end
        n_checks++;
        if ({w_hden, w_vfen, w_frame, w_irq, w_hsync, w_vsync} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_flags: hden,vfen,frame,irq,hs,vs=%b expected 000000",
                     {w_hden, w_vfen, w_frame, w_irq, w_hsync, w_vsync});
        end
        r_hspol = 1'b0;
        r_vspol = 1'b0;
        #1;
        n_checks++;
        if ({w_hsync, w_vsync} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_neg_sync: hs,vs=%b expected 11", {w_hsync, w_vsync});
        end
        r_hspol = 1'b1;
        r_vspol = 1'b1;
        @(posedge r_clk);
        #1;
        n_checks++;
        if (w_x !== CW'(0)) begin
            n_fail++;
            $display("FAIL reset_hold: x=%0d expected 0", w_x);
        end
        r_rst_n = 1'b1;
        m_n = 0;
        m_irq = 1'b0;
        step(1'b1, 1'b0);
        n_checks++;
        if (w_x !== CW'(1)) begin
            n_fail++;
            $display("FAIL first_dot: x=%0d expected 1", w_x);
        end
        step(1'b1, 1'b0);
        n_checks++;
        if (w_x !== CW'(2)) begin
            n_fail++;
            $display("FAIL second_dot: x=%0d expected 2", w_x);
        end
        repeat (3) step(1'b0, 1'b0);
        n_checks++;
        if (w_x !== CW'(2)) begin
            n_fail++;
            $display("FAIL dotce_hold: x=%0d expected 2", w_x);
        end
    endtask

    task automatic test_hsync();
        set_small();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_x !== CW'(mx()) || w_hsync !== ((mx() == 3 || mx() == 4) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL hsync_pos: x=%0d hs=%b expected x=%0d hs=%b", w_x, w_hsync,
                         mx(), (mx() == 3 || mx() == 4));
            end
        end
        r_hspol = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_hsync !== ((mx() == 3 || mx() == 4) ? 1'b0 : 1'b1)) begin
                n_fail++;
                $display("FAIL hsync_neg: x=%0d hs=%b expected %b", w_x, w_hsync,
                         !(mx() == 3 || mx() == 4));
            end
        end
        r_rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_hsync !== 1'b1) begin
            n_fail++;
            $display("FAIL hsync_neg_reset: hs=%b expected 1", w_hsync);
        end
    endtask

    task automatic test_vsync_frame();
        set_small();
        do_reset();
        for (int i = 0; i < 52; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_y !== CW'(my()) || w_vsync !== (my() == 2) ||
                w_frame !== (mx() == 0 && my() == 0)) begin
                n_fail++;
                $display("FAIL vsync_frame: x=%0d y=%0d vs=%b fr=%b expected y=%0d vs=%b fr=%b",
                         w_x, w_y, w_vsync, w_frame, my(), (my() == 2),
                         (mx() == 0 && my() == 0));
            end
        end
    endtask

    task automatic test_windows();
        set_small();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_hden !== (mx() >= 2 && mx() <= 4) || w_vfen !== (my() == 1 || my() == 2)) begin
                n_fail++;
                $display("FAIL windows: x=%0d y=%0d hden=%b vfen=%b expected %b %b", w_x, w_y,
                         w_hden, w_vfen, (mx() >= 2 && mx() <= 4), (my() == 1 || my() == 2));
            end
        end
    endtask

    task automatic test_irq();
        set_small();
        do_reset();
`ifdef CRTC2_RASTER_IRQ_EN
        while (m_n < 22) begin
            step(1'b1, 1'b0);
            n_checks++;
            if (w_irq !== (m_n >= 12)) begin
                n_fail++;
                $display("FAIL irq_rise: n=%0d irq=%b expected %b", m_n, w_irq, (m_n >= 12));
            end
        end
        step(1'b1, 1'b1);
        n_checks++;
        if (w_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_ack: irq=%b expected 0", w_irq);
        end
        while (m_n < 35) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        n_checks++;
        if (w_irq !== 1'b1 || w_y !== CW'(2)) begin
            n_fail++;
            $display("FAIL irq_set_wins: irq=%b y=%0d expected 1 2", w_irq, w_y);
        end
`else
        for (int i = 0; i < 30; i++) begin
            step(1'b1, ($urandom_range(3, 0) == 0));
            n_checks++;
            if (w_irq !== 1'b0) begin
                n_fail++;
                $display("FAIL irq_disabled: irq=%b expected 0", w_irq);
            end
        end
`endif
    endtask

    task automatic test_reset_midframe();
        set_small();
        do_reset();
        repeat (15) step(1'b1, 1'b0);
        n_checks++;
        if (w_x !== CW'(3) || w_y !== CW'(2) || w_vfen !== 1'b1 || w_hden !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pre: x=%0d y=%0d vfen=%b hden=%b expected 3 2 1 1",
                     w_x, w_y, w_vfen, w_hden);
        end
`ifdef CRTC2_RASTER_IRQ_EN
        n_checks++;
        if (w_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_irq_pre: irq=%b expected 1", w_irq);
        end
`endif
        #2;
        r_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({w_x, w_y} !== {CW'(0), CW'(0)} ||
            {w_hden, w_vfen, w_frame, w_irq, w_hsync, w_vsync} !== 6'b000000) begin
            n_fail++;
            $display("FAIL midframe_async: x=%0d y=%0d flags=%b expected 0 0 000000", w_x, w_y,
                     {w_hden, w_vfen, w_frame, w_irq, w_hsync, w_vsync});
        end
        repeat (2) @(posedge r_clk);
        #1;
        r_rst_n = 1'b1;
        m_n = 0;
        m_irq = 1'b0;
        step(1'b1, 1'b0);
        n_checks++;
        if (w_x !== CW'(1) || w_y !== CW'(0)) begin
            n_fail++;
            $display("FAIL midframe_restart: x=%0d y=%0d expected 1 0", w_x, w_y);
        end
    endtask

    task automatic test_random();
        int ncyc;
        for (int c = 0; c < 5; c++) begin
            r_htotal = CW'($urandom_range(40, 8));
            r_hss    = CW'($urandom_range(int'(r_htotal) - 1, 1));
            r_hse    = CW'($urandom_range(int'(r_htotal) + 3, int'(r_hss)));
            r_hvs    = CW'($urandom_range(int'(r_htotal) - 2, 0));
            r_hve    = CW'($urandom_range(int'(r_htotal), int'(r_hvs) + 1));
            r_vtotal = CW'($urandom_range(8, 3));
            r_vss    = CW'($urandom_range(int'(r_vtotal), 1));
            r_vse    = CW'($urandom_range(int'(r_vtotal) + 2, int'(r_vss)));
            r_vvs    = CW'($urandom_range(int'(r_vtotal) - 1, 0));
            r_vve    = CW'($urandom_range(int'(r_vtotal), int'(r_vvs) + 1));
            r_rcmp   = CW'($urandom_range(int'(r_vtotal), 0));
            r_hspol  = 1'($urandom_range(1, 0));
            r_vspol  = 1'($urandom_range(1, 0));
            do_reset();
            ncyc = 3 * (int'(r_htotal) + 1) * (int'(r_vtotal) + 1);
            for (int i = 0; i < ncyc; i++) begin
                step(($urandom_range(3, 0) != 0), ($urandom_range(15, 0) == 0));
                n_checks++;
                if (w_x !== CW'(mx()) || w_y !== CW'(my())) begin
                    n_fail++;
                    $display("FAIL rnd_xy: x=%0d y=%0d expected %0d %0d", w_x, w_y, mx(), my());
                end
                n_checks++;
                if (w_hsync !== e_hsync() || w_vsync !== e_vsync()) begin
                    n_fail++;
                    $display("FAIL rnd_sync: x=%0d y=%0d hs=%b vs=%b expected %b %b", w_x, w_y,
                             w_hsync, w_vsync, e_hsync(), e_vsync());
                end
                n_checks++;
                if (w_hden !== e_hden() || w_vfen !== e_vfen()) begin
                    n_fail++;
                    $display("FAIL rnd_win: x=%0d y=%0d hden=%b vfen=%b expected %b %b", w_x, w_y,
                             w_hden, w_vfen, e_hden(), e_vfen());
                end
                n_checks++;
                if (w_frame !== e_frame() || w_irq !== m_irq) begin
                    n_fail++;
                    $display("FAIL rnd_frame_irq: x=%0d y=%0d frame=%b irq=%b expected %b %b",
                             w_x, w_y, w_frame, w_irq, e_frame(), m_irq);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_vsync_frame();
        test_windows();
        test_irq();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
